alu_iter: RTL

//  Parametrised next-generation execute ALU. Adds iterative multiply/divide (MUL/MULU/DIV/DIVU)
//  to the single-cycle add/sub/shift/logic set. Uses a valid/ready issue handshake and a

---
 rtl/alu_iter_pkg.sv | 36 +++
 rtl/alu_iter_if.sv | 32 +++
 rtl/alu_iter_mdu.sv | 113 +++++++++++
 rtl/alu_iter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative execute ALU.
//   - Opcode encodings (single-cycle set plus MUL/MULU/DIV/DIVU).
//   - FSM state encodings for the top-level sequencer.
//   - Small opcode classification helpers.
package alu_iter_pkg;

   localparam int unsigned OpW = 5;

   localparam logic [OpW-1:0] OpAdd  = 5'd0;
   localparam logic [OpW-1:0] OpSub  = 5'd1;
   localparam logic [OpW-1:0] OpShl  = 5'd2;
   localparam logic [OpW-1:0] OpLsr  = 5'd3;
   localparam logic [OpW-1:0] OpAsr  = 5'd4;
   localparam logic [OpW-1:0] OpOr   = 5'd5;
   localparam logic [OpW-1:0] OpAnd  = 5'd6;
   localparam logic [OpW-1:0] OpNor  = 5'd7;
   localparam logic [OpW-1:0] OpXor  = 5'd8;
   localparam logic [OpW-1:0] OpMul  = 5'd9;
   localparam logic [OpW-1:0] OpMulu = 5'd10;
   localparam logic [OpW-1:0] OpDiv  = 5'd11;
   localparam logic [OpW-1:0] OpDivu = 5'd12;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMul  = 2'd1;
   localparam logic [1:0] StDiv  = 2'd2;
   localparam logic [1:0] StSign = 2'd3;

   function automatic logic is_mul_op(input logic [OpW-1:0] op);
      return (op == OpMul) || (op == OpMulu);
   endfunction

   function automatic logic is_div_op(input logic [OpW-1:0] op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Issue/result bundle of the iterative execute ALU.
//   master: issuing pipeline stage (drives request, flush; receives result and flags).
//   slave : alu_iter (receives request, flush; drives ready, result and flags).
interface alu_iter_if
   import alu_iter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic             valid_alu_i;
   logic             ready_alu_o;
   logic [OpW-1:0]   op_alu_i;
   logic [WIDTH-1:0] opr_a_alu_i;
   logic [WIDTH-1:0] opr_b_alu_i;
   logic             flush_alu_i;
   logic             res_valid_alu_o;
   logic [WIDTH-1:0] res_alu_o;
   logic [WIDTH-1:0] res_hi_alu_o;
   logic             z_alu_o;
   logic             ovf_alu_o;
   logic             dz_alu_o;

   modport master (
      output valid_alu_i, op_alu_i, opr_a_alu_i, opr_b_alu_i, flush_alu_i,
      input  ready_alu_o, res_valid_alu_o, res_alu_o, res_hi_alu_o, z_alu_o, ovf_alu_o, dz_alu_o
   );

   modport slave (
      input  valid_alu_i, op_alu_i, opr_a_alu_i, opr_b_alu_i, flush_alu_i,
      output ready_alu_o, res_valid_alu_o, res_alu_o, res_hi_alu_o, z_alu_o, ovf_alu_o, dz_alu_o
   );

endinterface

// File: rtl/alu_iter_mdu.sv
// Iterative multiply/divide unit (mdu_iter) used by alu_iter.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            load operands (magnitudes), signs and counter
//   is_div/is_signed operation class sampled at start
//   opr_a, opr_b     operands, sampled only at start
//   step             perform one iteration (one product/quotient bit)
//   cnt_zero         current step is the last one
//   res_lo, res_hi   sign-corrected product (lo/hi) or quotient/remainder
module alu_iter_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] opr_a,
   input  logic [WIDTH-1:0] opr_b,
   input  logic             step,
   output logic             cnt_zero,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);
   localparam int unsigned CntW = $clog2(WIDTH);

   // acc: MUL {partial product, remaining multiplier}; DIV {partial remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q, opd_d;  // multiplicand or divisor magnitude
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               div_q, div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] prod_neg;

   assign mag_a = (is_signed && opr_a[WIDTH-1]) ? -opr_a : opr_a;
   assign mag_b = (is_signed && opr_b[WIDTH-1]) ? -opr_b : opr_b;

   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opd_q};
   assign cnt_zero  = (cnt_q == '0);

   always_comb begin
      acc_d    = acc_q;
      opd_d    = opd_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (start) begin
         div_d    = is_div;
         cnt_d    = CntW'(WIDTH - 1);
         // MUL: neg_lo negates the whole product. DIV: quotient and remainder separately.
         neg_lo_d = is_signed & (opr_a[WIDTH-1] ^ opr_b[WIDTH-1]);
         neg_hi_d = is_signed & is_div & opr_a[WIDTH-1];
         if (is_div) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            opd_d = mag_b;
         end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            opd_d = mag_a;
         end
      end else if (step) begin
         cnt_d = cnt_q - CntW'(1);
         if (div_q) begin
            // Restoring step: keep the trial difference only when it did not go negative.
            if (!div_trial[WIDTH]) begin
               acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         opd_q    <= '0;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   // Two's-complement fix-up, sampled by the top on its SIGN->IDLE edge.
   assign prod_neg = -acc_q;

   always_comb begin
      if (div_q) begin
         res_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end else if (neg_lo_q) begin
         {res_hi, res_lo} = prod_neg;
      end else begin
         {res_hi, res_lo} = acc_q;
      end
   end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU with iterative multiply/divide.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         alu_iter_if.slave: valid/ready issue, opcode, operands, flush,
//               registered result (lo/hi) with zero, overflow and divide-by-zero flags
// Single-cycle ops return one cycle after issue; MUL/DIV take WIDTH+2 cycles and hold
// ready low while busy. Divide by zero returns immediately with dz set.
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst_n,
   alu_iter_if.slave bus
);
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
   logic             z_q, z_d, ovf_q, ovf_d, dz_q, dz_d, res_valid_q, res_valid_d;

   logic             issue, is_mul, is_div, op_signed, b_zero;
   logic             mdu_start, mdu_step, mdu_cnt_zero;
   logic [WIDTH-1:0] mdu_lo, mdu_hi;

   logic             sub_op, alu_ovf;
   logic [WIDTH-1:0] b_add, sum, alu_res;
   logic [SHAMT_W-1:0] shamt;

   assign issue     = bus.valid_alu_i & (state_q == StIdle) & ~bus.flush_alu_i;
   assign is_mul    = is_mul_op(bus.op_alu_i);
   assign is_div    = is_div_op(bus.op_alu_i);
   assign op_signed = (bus.op_alu_i == OpMul) || (bus.op_alu_i == OpDiv);
   assign b_zero    = (bus.opr_b_alu_i == '0);
   assign mdu_start = issue & (is_mul | (is_div & ~b_zero));
   assign mdu_step  = ((state_q == StMul) || (state_q == StDiv)) & ~bus.flush_alu_i;

   // Single-cycle datapath: shared adder (SUB = A + ~B + 1), shifter, logic.
   assign sub_op = (bus.op_alu_i == OpSub);
   assign b_add  = sub_op ? ~bus.opr_b_alu_i : bus.opr_b_alu_i;
   assign sum    = bus.opr_a_alu_i + b_add + {{(WIDTH-1){1'b0}}, sub_op};
   assign shamt  = bus.opr_b_alu_i[SHAMT_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.op_alu_i)
         OpAdd, OpSub: begin
            alu_res = sum;
            alu_ovf = (bus.opr_a_alu_i[WIDTH-1] == b_add[WIDTH-1]) &
                      (sum[WIDTH-1] != bus.opr_a_alu_i[WIDTH-1]);
         end
         OpShl:   alu_res = bus.opr_a_alu_i << shamt;
         OpLsr:   alu_res = bus.opr_a_alu_i >> shamt;
         OpAsr:   alu_res = $signed(bus.opr_a_alu_i) >>> shamt;
         OpOr:    alu_res = bus.opr_a_alu_i | bus.opr_b_alu_i;
         OpAnd:   alu_res = bus.opr_a_alu_i & bus.opr_b_alu_i;
         OpNor:   alu_res = ~(bus.opr_a_alu_i | bus.opr_b_alu_i);
         OpXor:   alu_res = bus.opr_a_alu_i ^ bus.opr_b_alu_i;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      res_hi_d    = res_hi_q;
      z_d         = z_q;
      ovf_d       = ovf_q;
      dz_d        = dz_q;
      res_valid_d = 1'b0;
      if (bus.flush_alu_i) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (issue) begin
                  if (is_mul) begin
                     state_d = StMul;
                  end else if (is_div && !b_zero) begin
                     state_d = StDiv;
                  end else if (is_div) begin
                     res_valid_d = 1'b1;
                     res_d       = '1;
                     res_hi_d    = bus.opr_a_alu_i;
                     ovf_d       = 1'b0;
                     dz_d        = 1'b1;
                  end else begin
                     res_valid_d = 1'b1;
                     res_d       = alu_res;
                     res_hi_d    = '0;
                     ovf_d       = alu_ovf;
                     dz_d        = 1'b0;
                  end
               end
            end
            StMul, StDiv: begin
               if (mdu_cnt_zero) state_d = StSign;
            end
            StSign: begin
               state_d     = StIdle;
               res_valid_d = 1'b1;
               res_d       = mdu_lo;
               res_hi_d    = mdu_hi;
               ovf_d       = 1'b0;
               dz_d        = 1'b0;
            end
            default: state_d = StIdle;
         endcase
      end
      if (res_valid_d) z_d = (res_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         res_q       <= '0;
         res_hi_q    <= '0;
         z_q         <= 1'b0;
         ovf_q       <= 1'b0;
         dz_q        <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         res_hi_q    <= res_hi_d;
         z_q         <= z_d;
         ovf_q       <= ovf_d;
         dz_q        <= dz_d;
         res_valid_q <= res_valid_d;
      end
   end

   alu_iter_mdu #(
      .WIDTH (WIDTH)
   ) u_mdu (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (mdu_start),
      .is_div    (is_div),
      .is_signed (op_signed),
      .opr_a     (bus.opr_a_alu_i),
      .opr_b     (bus.opr_b_alu_i),
      .step      (mdu_step),
      .cnt_zero  (mdu_cnt_zero),
      .res_lo    (mdu_lo),
      .res_hi    (mdu_hi)
   );

   assign bus.ready_alu_o     = (state_q == StIdle);
   assign bus.res_valid_alu_o = res_valid_q;
   assign bus.res_alu_o       = res_q;
   assign bus.res_hi_alu_o    = res_hi_q;
   assign bus.z_alu_o         = z_q;
   assign bus.ovf_alu_o       = ovf_q;
   assign bus.dz_alu_o        = dz_q;

endmodule
